// File: rtl/internal_pkg.sv
// rtl/internal_pkg.sv - internal CSR bus type and sync counter bank definitions
package internal_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [63:0] data;
  } t_if_internal;

  localparam logic [1:0] SCB_REG_LOAD = 2'd0;
  localparam logic [1:0] SCB_REG_CTRL = 2'd1;
  localparam logic [1:0] SCB_REG_DEC  = 2'd2;
  localparam logic [1:0] SCB_REG_SUB  = 2'd3;

  typedef struct packed {
    logic pulse;
    logic sat;
  } t_scb_ctrl;

  typedef enum logic [2:0] {NOP, LOAD, CTRL, DEC, SUB} t_scb_op;

  function automatic t_scb_op scb_reg_to_op(input logic [1:0] r);
    case (r)
      SCB_REG_LOAD: return LOAD;
      SCB_REG_CTRL: return CTRL;
      SCB_REG_DEC:  return DEC;
      default:      return SUB;
    endcase
  endfunction

endpackage

// File: rtl/sync_counter_ch.sv
// rtl/sync_counter_ch.sv - one down-counter channel with level/pulse sync flag
module sync_counter_ch
  import internal_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  t_scb_op          op,
  input  logic [CNT_W-1:0] operand,
  output logic             sync,
  output logic             is_zero
);

  logic [CNT_W-1:0] cnt;
  t_scb_ctrl        ctrl;
  logic             zero_q;

  assign is_zero = (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '1;
      ctrl   <= '0;
      zero_q <= 1'b0;
      sync   <= 1'b0;
    end else begin
      // zero_q remembers the previous cycle's zero state so a pulse fires only on arrival
      zero_q <= is_zero;
      sync   <= ctrl.pulse ? (is_zero && !zero_q) : is_zero;
      case (op)
        LOAD: begin
          cnt    <= operand;
          zero_q <= 1'b0;
        end
        CTRL: begin
          ctrl.pulse <= operand[0];
          ctrl.sat   <= operand[1];
        end
        DEC: begin
          if (!(ctrl.sat && is_zero)) cnt <= cnt - 1'b1;
        end
        SUB: begin
          if (ctrl.sat && (operand > cnt)) cnt <= '0;
          else                             cnt <= cnt - operand;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sync_counter_bank.sv
// rtl/sync_counter_bank.sv - CSR-driven bank of NUM_CH sync down-counters
module sync_counter_bank
  import internal_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 64,
  parameter int BASE_ADDR = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  t_if_internal      pkt_in,
  output logic [NUM_CH-1:0] sync,
  output logic              sync_all
);

  logic [31:0]      off;
  logic             in_base;
  t_scb_op          op_d [NUM_CH];
  t_scb_op          op_q [NUM_CH];
  logic [CNT_W-1:0] operand_q;
  logic [NUM_CH-1:0] is_zero;

  assign off     = pkt_in.addr - 32'(BASE_ADDR);
  assign in_base = pkt_in.valid && (pkt_in.addr >= 32'(BASE_ADDR));

  // Offset 4*NUM_CH is the broadcast decrement; anything beyond is dropped
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      op_d[c] = NOP;
      if (in_base) begin
        if (off == 32'(4 * NUM_CH))
          op_d[c] = DEC;
        else if ((off < 32'(4 * NUM_CH)) && ((off >> 2) == 32'(c)))
          op_d[c] = scb_reg_to_op(off[1:0]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) op_q[c] <= NOP;
      operand_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) op_q[c] <= op_d[c];
      operand_q <= pkt_in.data[CNT_W-1:0];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sync_counter_ch #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .op      (op_q[c]),
      .operand (operand_q),
      .sync    (sync[c]),
      .is_zero (is_zero[c])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) sync_all <= 1'b0;
    else       sync_all <= &is_zero;
  end

endmodule

// File: tb/tb_sync_counter_bank.sv
// tb/tb_sync_counter_bank.sv - directed self-checking bench for sync_counter_bank
module tb_sync_counter_bank;
  import internal_pkg::*;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  t_if_internal pkt_in = '0;
  logic [3:0]   sync;
  logic         sync_all;
  int           n_checks = 0;
  int           n_fail = 0;

  sync_counter_bank #(.NUM_CH(4), .CNT_W(64), .BASE_ADDR(128)) dut (
    .clk      (clk),
    .reset    (reset),
    .pkt_in   (pkt_in),
    .sync     (sync),
    .sync_all (sync_all)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input logic [31:0] a, input logic [63:0] d);
    @(negedge clk);
    pkt_in.valid = 1'b1;
    pkt_in.addr  = a;
    pkt_in.data  = d;
    @(negedge clk);
    pkt_in = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (sync !== 4'b0000) begin n_fail++; $display("FAIL reset_sync got %b want 0000", sync); end
    n_checks++; if (sync_all !== 1'b0) begin n_fail++; $display("FAIL reset_sync_all got %b want 0", sync_all); end
    n_checks++; if (dut.g_ch[0].u_ch.cnt !== ONES) begin n_fail++; $display("FAIL reset_cnt0 got %h want %h", dut.g_ch[0].u_ch.cnt, ONES); end
    n_checks++; if (dut.g_ch[3].u_ch.cnt !== ONES) begin n_fail++; $display("FAIL reset_cnt3 got %h want %h", dut.g_ch[3].u_ch.cnt, ONES); end
    write(130, 0);
    idle(1);
    n_checks++; if (dut.g_ch[0].u_ch.cnt !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL reset_dec got %h want fffffffffffffffe", dut.g_ch[0].u_ch.cnt); end
    idle(1);
    n_checks++; if (sync !== 4'b0000) begin n_fail++; $display("FAIL reset_dec_sync got %b want 0000", sync); end
  endtask

  task automatic test_level();
    logic [63:0] exp_cnt;
    do_reset();
    write(128, 3);
    for (int i = 2; i >= 0; i--) begin
      write(130, 0);
      idle(1);
      exp_cnt = 64'(i);
      n_checks++; if (dut.g_ch[0].u_ch.cnt !== exp_cnt) begin n_fail++; $display("FAIL level_cnt step %0d got %h want %h", i, dut.g_ch[0].u_ch.cnt, exp_cnt); end
    end
    n_checks++; if (sync[0] !== 1'b0) begin n_fail++; $display("FAIL level_sync_early got %b want 0", sync[0]); end
    idle(1);
    n_checks++; if (sync[0] !== 1'b1) begin n_fail++; $display("FAIL level_sync_rise got %b want 1", sync[0]); end
    idle(2);
    n_checks++; if (sync[0] !== 1'b1) begin n_fail++; $display("FAIL level_sync_hold got %b want 1", sync[0]); end
    write(130, 0);
    idle(1);
    n_checks++; if (dut.g_ch[0].u_ch.cnt !== ONES) begin n_fail++; $display("FAIL level_wrap got %h want %h", dut.g_ch[0].u_ch.cnt, ONES); end
    n_checks++; if (sync[0] !== 1'b1) begin n_fail++; $display("FAIL level_sync_lag got %b want 1", sync[0]); end
    idle(1);
    n_checks++; if (sync[0] !== 1'b0) begin n_fail++; $display("FAIL level_sync_drop got %b want 0", sync[0]); end
  endtask

  task automatic test_pulse();
    do_reset();
    write(133, 1);
    write(132, 2);
    write(134, 0);
    write(134, 0);
    idle(1);
    n_checks++; if (dut.g_ch[1].u_ch.cnt !== 64'd0) begin n_fail++; $display("FAIL pulse_cnt got %h want 0", dut.g_ch[1].u_ch.cnt); end
    n_checks++; if (sync[1] !== 1'b0) begin n_fail++; $display("FAIL pulse_pre got %b want 0", sync[1]); end
    idle(1);
    n_checks++; if (sync[1] !== 1'b1) begin n_fail++; $display("FAIL pulse_high got %b want 1", sync[1]); end
    idle(1);
    n_checks++; if (sync[1] !== 1'b0) begin n_fail++; $display("FAIL pulse_low got %b want 0", sync[1]); end
    write(134, 0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      n_checks++; if (sync[1] !== 1'b0) begin n_fail++; $display("FAIL pulse_wrap_quiet cycle %0d got %b want 0", i, sync[1]); end
    end
    n_checks++; if (dut.g_ch[1].u_ch.cnt !== ONES) begin n_fail++; $display("FAIL pulse_wrap_cnt got %h want %h", dut.g_ch[1].u_ch.cnt, ONES); end
    write(132, 0);
    idle(1);
    n_checks++; if (sync[1] !== 1'b0) begin n_fail++; $display("FAIL pulse_load0_pre got %b want 0", sync[1]); end
    idle(1);
    n_checks++; if (sync[1] !== 1'b1) begin n_fail++; $display("FAIL pulse_load0_high got %b want 1", sync[1]); end
    idle(1);
    n_checks++; if (sync[1] !== 1'b0) begin n_fail++; $display("FAIL pulse_load0_low got %b want 0", sync[1]); end
  endtask

  task automatic test_saturate();
    do_reset();
    write(137, 2);
    write(136, 5);
    write(139, 9);
    idle(1);
    n_checks++; if (dut.g_ch[2].u_ch.cnt !== 64'd0) begin n_fail++; $display("FAIL sat_sub got %h want 0", dut.g_ch[2].u_ch.cnt); end
    idle(1);
    n_checks++; if (sync[2] !== 1'b1) begin n_fail++; $display("FAIL sat_sync got %b want 1", sync[2]); end
    write(138, 0);
    idle(1);
    n_checks++; if (dut.g_ch[2].u_ch.cnt !== 64'd0) begin n_fail++; $display("FAIL sat_dec_hold got %h want 0", dut.g_ch[2].u_ch.cnt); end
    n_checks++; if (sync[2] !== 1'b1) begin n_fail++; $display("FAIL sat_sync_hold got %b want 1", sync[2]); end
    write(137, 0);
    write(136, 5);
    write(139, 9);
    idle(1);
    n_checks++; if (dut.g_ch[2].u_ch.cnt !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL mod_sub got %h want fffffffffffffffc", dut.g_ch[2].u_ch.cnt); end
    idle(1);
    n_checks++; if (sync[2] !== 1'b0) begin n_fail++; $display("FAIL mod_sync got %b want 0", sync[2]); end
  endtask

  task automatic test_broadcast();
    do_reset();
    write(128, 1);
    write(132, 1);
    write(136, 1);
    write(140, 1);
    write(144, 0);
    idle(1);
    n_checks++; if (dut.g_ch[0].u_ch.cnt !== 64'd0 || dut.g_ch[3].u_ch.cnt !== 64'd0)
      begin n_fail++; $display("FAIL bcast_cnt got %h/%h want 0/0", dut.g_ch[0].u_ch.cnt, dut.g_ch[3].u_ch.cnt); end
    n_checks++; if (sync_all !== 1'b0) begin n_fail++; $display("FAIL bcast_all_early got %b want 0", sync_all); end
    idle(1);
    n_checks++; if (sync_all !== 1'b1) begin n_fail++; $display("FAIL bcast_all got %b want 1", sync_all); end
    n_checks++; if (sync !== 4'b1111) begin n_fail++; $display("FAIL bcast_sync got %b want 1111", sync); end
    write(145, 5);
    write(127, 5);
    idle(2);
    n_checks++; if (dut.g_ch[1].u_ch.cnt !== 64'd0 || dut.g_ch[2].u_ch.cnt !== 64'd0)
      begin n_fail++; $display("FAIL oor_cnt got %h/%h want 0/0", dut.g_ch[1].u_ch.cnt, dut.g_ch[2].u_ch.cnt); end
    n_checks++; if (sync_all !== 1'b1) begin n_fail++; $display("FAIL oor_all got %b want 1", sync_all); end
  endtask

  task automatic test_back_to_back_reset();
    do_reset();
    write(143, 3);
    write(140, 2);
    idle(2);
    @(negedge clk);
    reset = 1'b1;
    pkt_in.valid = 1'b1;
    pkt_in.addr  = 142;
    pkt_in.data  = 0;
    @(negedge clk);
    reset = 1'b0;
    pkt_in = '0;
    n_checks++; if (sync !== 4'b0000 || sync_all !== 1'b0) begin n_fail++; $display("FAIL mid_reset_out got %b/%b want 0000/0", sync, sync_all); end
    n_checks++; if (dut.g_ch[3].u_ch.cnt !== ONES) begin n_fail++; $display("FAIL mid_reset_cnt got %h want %h", dut.g_ch[3].u_ch.cnt, ONES); end
    n_checks++; if (dut.g_ch[3].u_ch.ctrl !== 2'b00) begin n_fail++; $display("FAIL mid_reset_ctrl got %b want 00", dut.g_ch[3].u_ch.ctrl); end
    idle(2);
    n_checks++; if (dut.g_ch[3].u_ch.cnt !== ONES) begin n_fail++; $display("FAIL mid_reset_dropdec got %h want %h", dut.g_ch[3].u_ch.cnt, ONES); end
    write(140, 1);
    write(142, 0);
    idle(1);
    n_checks++; if (dut.g_ch[3].u_ch.cnt !== 64'd0) begin n_fail++; $display("FAIL post_reset_cnt got %h want 0", dut.g_ch[3].u_ch.cnt); end
    idle(1);
    n_checks++; if (sync[3] !== 1'b1) begin n_fail++; $display("FAIL post_reset_sync got %b want 1", sync[3]); end
    idle(2);
    n_checks++; if (sync[3] !== 1'b1) begin n_fail++; $display("FAIL post_reset_level got %b want 1", sync[3]); end
  endtask

  initial begin
    test_reset();
    test_level();
    test_pulse();
    test_saturate();
    test_broadcast();
    test_back_to_back_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
